// File: rtl/counter_event_fifo_if.sv
// Event-FIFO bus: mode-counter outputs in, tagged event words and status out.
// The master side is the counter plus the consumer; the slave side is the FIFO.
interface counter_event_fifo_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    logic [3:0]               cnt_q;
    logic                     cnt_rco;
    logic                     cnt_load;
    logic [1:0]               cnt_mode;
    logic                     out_ready;
    logic                     clr_ovf;
    logic                     out_valid;
    logic [7:0]               out_data;
    logic [$clog2(DEPTH):0]   level;
    logic                     full;
    logic                     overflow;
    logic [CNT_W-1:0]         evt_count;

    modport master (
        output cnt_q, cnt_rco, cnt_load, cnt_mode, out_ready, clr_ovf,
        input  out_valid, out_data, level, full, overflow, evt_count
    );

    modport slave (
        input  cnt_q, cnt_rco, cnt_load, cnt_mode, out_ready, clr_ovf,
        output out_valid, out_data, level, full, overflow, evt_count
    );
endinterface

// File: rtl/counter_event_fifo.sv
// Turns mode-counter rollovers and load entries into tagged event words,
// buffered in a first-word-fall-through FIFO with a saturating event count.
module counter_event_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_event_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [1:0] mode;
        logic       load_evt;
        logic       rco_evt;
        logic [3:0] q;
    } evt_t;

    // rco only lives for half a cycle, so it is caught on the falling edge
    // together with the Q/mode it rolled over into.
    logic       rco_cap_q;
    logic [3:0] q_sh_q;
    logic [1:0] mode_sh_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rco_cap_q <= 1'b0;
            q_sh_q    <= '0;
            mode_sh_q <= '0;
        end else begin
            rco_cap_q <= bus.cnt_rco;
            q_sh_q    <= bus.cnt_q;
            mode_sh_q <= bus.cnt_mode;
        end
    end

    logic             load_d_q;
    evt_t             mem_q [DEPTH];
    logic [AW:0]      wcnt_q, wcnt_d;
    logic [AW:0]      rcnt_q, rcnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

    logic        rco_evt, load_evt, push, pop, accept, drop, full, valid;
    logic [AW:0] level;
    evt_t        push_word;

    always_comb begin
        level    = wcnt_q - rcnt_q;
        full     = (level == FULL_LVL);
        valid    = (level != '0);
        rco_evt  = rco_cap_q;
        load_evt = bus.cnt_load & ~load_d_q;
        push     = rco_evt | load_evt;
        pop      = valid & bus.out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        accept   = push & (~full | pop);
        drop     = push & full & ~pop;

        push_word.load_evt = load_evt;
        push_word.rco_evt  = rco_evt;
        if (rco_evt) begin
            push_word.mode = mode_sh_q;
            push_word.q    = q_sh_q;
        end else begin
            push_word.mode = bus.cnt_mode;
            push_word.q    = bus.cnt_q;
        end
    end

    always_comb begin
        wcnt_d    = wcnt_q + {{AW{1'b0}}, accept};
        rcnt_d    = rcnt_q + {{AW{1'b0}}, pop};
        evt_cnt_d = evt_cnt_q;
        if (accept && (evt_cnt_q != {CNT_W{1'b1}}))
            evt_cnt_d = evt_cnt_q + CNT_W'(1);
        ovf_d = ovf_q;
        if (drop)
            ovf_d = 1'b1;
        else if (bus.clr_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_d_q  <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            ovf_q     <= 1'b0;
            evt_cnt_q <= '0;
        end else begin
            load_d_q  <= bus.cnt_load;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            ovf_q     <= ovf_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (accept) begin
            mem_q[wcnt_q[AW-1:0]] <= push_word;
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? mem_q[rcnt_q[AW-1:0]] : 8'h00;
    assign bus.level     = level;
    assign bus.full      = full;
    assign bus.overflow  = ovf_q;
    assign bus.evt_count = evt_cnt_q;
endmodule

// File: tb/tb_counter_event_fifo.sv
// Directed bench: a behavioural 4-bit mode counter drives the event FIFO;
// expected words and status are hand-computed per vector row.
module tb_counter_event_fifo;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset;

    counter_event_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    counter_event_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] mode;
        logic       en;
        logic [3:0] d;
        logic       rdy;
        logic       clr;
        int         n;
        logic       ev;
        logic [7:0] ed;
        int         el;
        logic       eo;
        int         ec;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [1:0] m, input logic en, input logic [3:0] d,
                                input logic rdy, input int n, input logic ev,
                                input logic [7:0] ed, input int el, input int ec);
        vec_t v;
        v.mode = m; v.en = en; v.d = d; v.rdy = rdy; v.clr = 1'b0; v.n = n;
        v.ev = ev; v.ed = ed; v.el = el; v.eo = 1'b0; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [7:0] ed,
                           input int el, input logic eo, input int ec);
        chk({nm, ".valid"}, 32'(bus.out_valid), 32'(ev));
        if (ev) chk({nm, ".data"}, 32'(bus.out_data), 32'(ed));
        chk({nm, ".level"}, 32'(bus.level), 32'(el));
        chk({nm, ".full"}, 32'(bus.full), 32'(el == DEPTH));
        chk({nm, ".ovf"}, 32'(bus.overflow), 32'(eo));
        chk({nm, ".cnt"}, 32'(bus.evt_count), 32'(ec));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".data"}, 32'(bus.out_data), 32'h0);
        chk_out(nm, 1'b0, 8'h00, 0, 1'b0, 0);
    endtask

    // Behavioural mode counter: Q/load/rco change just after posedge,
    // rco drops just after the following negedge.
    task automatic cstep(input logic [1:0] m, input logic en, input logic [3:0] d);
        logic [3:0] q;
        q = bus.cnt_q;
        bus.cnt_mode = m;
        bus.cnt_rco  = 1'b0;
        bus.cnt_load = (m == 2'd3);
        if (!en) begin
            bus.cnt_q = 4'd0;
        end else begin
            case (m)
                2'd0: begin
                    if (q == 4'd15) bus.cnt_rco = 1'b1;
                    bus.cnt_q = q + 4'd1;
                end
                2'd1: begin
                    if (q == 4'd0) bus.cnt_rco = 1'b1;
                    bus.cnt_q = q - 4'd1;
                end
                2'd2: begin
                    if (q < 4'd3) bus.cnt_rco = 1'b1;
                    bus.cnt_q = q - 4'd3;
                end
                default: bus.cnt_q = d;
            endcase
        end
    endtask

    task automatic tick(input logic [1:0] m, input logic en, input logic [3:0] d,
                        input logic rdy, input logic clr);
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        @(posedge clk);
        #1;
        cstep(m, en, d);
        @(negedge clk);
        #1;
        bus.cnt_rco = 1'b0;
    endtask

    logic [7:0] drain_exp [3];

    initial begin
        reset = 1'b0;
        bus.cnt_q = 4'd0; bus.cnt_rco = 1'b0; bus.cnt_load = 1'b0; bus.cnt_mode = 2'd0;
        bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;

        //            mode  en    d     rdy   n   ev    data   lvl cnt
        vq.push_back(mk(2'd0, 1'b1, 4'd0, 1'b0, 15, 1'b0, 8'h00, 0, 0));
        vq.push_back(mk(2'd0, 1'b1, 4'd0, 1'b0, 1,  1'b0, 8'h00, 0, 0));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b0, 1,  1'b1, 8'h10, 1, 1));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b1, 1,  1'b0, 8'h00, 0, 1));
        vq.push_back(mk(2'd0, 1'b1, 4'd0, 1'b0, 1,  1'b0, 8'h00, 0, 1));
        vq.push_back(mk(2'd2, 1'b1, 4'd0, 1'b0, 1,  1'b0, 8'h00, 0, 1));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b0, 1,  1'b1, 8'h9E, 1, 2));
        vq.push_back(mk(2'd1, 1'b1, 4'd0, 1'b0, 1,  1'b1, 8'h9E, 1, 2));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b0, 1,  1'b1, 8'h9E, 2, 3));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b1, 1,  1'b1, 8'h5F, 1, 3));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b1, 1,  1'b0, 8'h00, 0, 3));
        vq.push_back(mk(2'd3, 1'b1, 4'd9, 1'b0, 1,  1'b0, 8'h00, 0, 3));
        vq.push_back(mk(2'd3, 1'b1, 4'd9, 1'b0, 4,  1'b1, 8'hE9, 1, 4));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b0, 1,  1'b1, 8'hE9, 1, 4));
        vq.push_back(mk(2'd3, 1'b1, 4'd9, 1'b0, 1,  1'b1, 8'hE9, 1, 4));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b0, 1,  1'b1, 8'hE9, 2, 5));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b1, 2,  1'b0, 8'h00, 0, 5));
        vq.push_back(mk(2'd3, 1'b0, 4'd0, 1'b0, 1,  1'b0, 8'h00, 0, 5));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b0, 1,  1'b1, 8'hE0, 1, 6));
        vq.push_back(mk(2'd0, 1'b0, 4'd0, 1'b1, 1,  1'b0, 8'h00, 0, 6));

        #12;
        chk_zero("reset");
        reset = 1'b1;

        foreach (vq[i]) begin
            repeat (vq[i].n) tick(vq[i].mode, vq[i].en, vq[i].d, vq[i].rdy, vq[i].clr);
            chk_out($sformatf("row%0d", i), vq[i].ev, vq[i].ed, vq[i].el, vq[i].eo, vq[i].ec);
        end

        // Fill past capacity with alternating mode-1 / mode-2 rollovers.
        reset = 1'b0;
        #1;
        chk_zero("reset2");
        #1;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick((k % 2 == 1) ? 2'd2 : 2'd1, 1'b1, 4'd0, 1'b0, 1'b0);
            tick(2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        chk_out("fill", 1'b1, 8'h5F, 4, 1'b1, 4);
        tick(2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk_out("ovf_hold", 1'b1, 8'h5F, 4, 1'b1, 4);
        tick(2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk_out("ovf_clr", 1'b1, 8'h5F, 4, 1'b0, 4);

        // Drop and clear in the same cycle: set wins.
        tick(2'd1, 1'b1, 4'd0, 1'b0, 1'b0);
        tick(2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk_out("set_wins", 1'b1, 8'h5F, 4, 1'b1, 4);
        tick(2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk_out("ovf_clr2", 1'b1, 8'h5F, 4, 1'b0, 4);

        // Push and pop together while full.
        tick(2'd2, 1'b1, 4'd0, 1'b0, 1'b0);
        tick(2'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_out("full_pushpop", 1'b1, 8'h9D, 4, 1'b0, 5);

        drain_exp[0] = 8'h5F; drain_exp[1] = 8'h9D; drain_exp[2] = 8'h9D;
        for (int k = 0; k < 3; k++) begin
            tick(2'd0, 1'b0, 4'd0, 1'b1, 1'b0);
            chk_out($sformatf("drain%0d", k), 1'b1, drain_exp[k], 3 - k, 1'b0, 5);
        end
        tick(2'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_out("drain_empty", 1'b0, 8'h00, 0, 1'b0, 5);

        // Refill two, pop one, then reset between edges.
        tick(2'd1, 1'b1, 4'd0, 1'b0, 1'b0);
        tick(2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(2'd2, 1'b1, 4'd0, 1'b0, 1'b0);
        tick(2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk_out("refill", 1'b1, 8'h5F, 2, 1'b0, 7);
        tick(2'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_out("mid_drain", 1'b1, 8'h9D, 1, 1'b0, 7);
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        #2;
        reset = 1'b1;
        tick(2'd1, 1'b1, 4'd0, 1'b0, 1'b0);
        chk_out("post_rst_pulse", 1'b0, 8'h00, 0, 1'b0, 0);
        tick(2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk_out("post_rst_evt", 1'b1, 8'h5F, 1, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_event_fifo.md
Name: counter_event_fifo

Overview:
- Downstream stage of the 4-bit mode counter. Consumes its Q, rco, load and mode outputs.
- Turns each rollover (rco) and each load entry into a tagged event word, buffered in a small FIFO.
- Delivers event words to the consumer (cascade logic or scoreboard/checker) over a valid/ready handshake.
- Keeps a saturating event count and a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating event counter.

Ports:
- clk  input  1  single clock; all state on posedge except the rco capture flop (negedge, same clock).
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- cnt_q  input  4  counter Q.
- cnt_rco  input  1  counter rco: half-cycle pulse, set at posedge, cleared at the following negedge.
- cnt_load  input  1  counter load: level, held while the counter is in load mode.
- cnt_mode  input  2  counter mode (0 +1, 1 -1, 2 -3, 3 load).
- out_ready  input  1  consumer accepts the head entry.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- out_valid  output  1  FIFO non-empty.
- out_data  output  8  head entry: [7:6] mode, [5] load_evt, [4] rco_evt, [3:0] Q.
- level  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky; set when an event is dropped.
- evt_count  output  CNT_W  total events accepted, saturating at all-ones.

Behaviour:
- Reset (reset=0, async): out_valid=0, out_data=0, level=0, full=0, overflow=0, evt_count=0, rco capture flop=0, load history flop=0, pointers=0.
- rco capture:
  - A negedge flop samples cnt_rco, which is still 1 at that edge because the counter clears it non-blocking.
  - The same negedge also samples cnt_q and cnt_mode into the shadow registers q_sh and mode_sh.
  - rco_evt = captured rco, seen at the next posedge.
- load detect: load_evt = cnt_load & ~load_d at posedge; load_d <= cnt_load. A held load gives exactly one event.
- Event word pushed at posedge when rco_evt | load_evt:
  - Q and mode fields come from q_sh and mode_sh when rco_evt=1, otherwise from cnt_q and cnt_mode.
  - Both flags set when both events coincide; this gives a single entry, not two.
- Latency: rco pulse after posedge k → entry visible, out_valid=1, after posedge k+1 when the FIFO was empty. Load edge at posedge k → visible after posedge k+1.
- Pop: out_valid & out_ready at posedge advances the read pointer. out_data is the head, combinational from storage (first-word fall-through).
- Simultaneous push and pop:
  - Allowed at any level, including full.
  - At full, the pop frees the slot and the push is accepted: level unchanged, no overflow.
  - At empty, the push is accepted and the pop is ignored, since out_valid was 0.
- Push while full with no pop: entry dropped, overflow <= 1, evt_count not incremented.
- overflow holds until clr_ovf=1 at a posedge or reset. If a drop and clr_ovf occur in the same cycle, set wins.
- evt_count increments on every accepted push and holds at 2^CNT_W-1.
- Pointers wrap modulo DEPTH. level is derived from a write/read counter pair with one extra bit.
- Counter enable=0 drives Q=0: ignored unless it comes with a load edge (mode 3, enable 0 raises load), which produces a load event with Q=0.
- Reset asserted mid-operation: everything clears at once, with no partial pop. Deassertion is followed by normal operation at the next posedge. A pending captured rco is lost.

Test Plan:
- Reset, then counter mode 0 from Q=0 for 16 posedges → one entry {mode=0, load=0, rco=1, Q=0}, out_valid rises one posedge after the rco pulse, evt_count=1.
- Mode 2 from Q=1 (Q=1 wraps to 14) → entry rco=1, Q=14, mode=2. Mode 1 at Q=0 → entry rco=1, Q=15, mode=1.
- Mode 3 with D=9 held for 5 cycles → exactly one entry {mode=3, load=1, rco=0, Q=9}. Release, re-enter → second entry.
- out_ready=0, generate 5 rco events with DEPTH=4 → level=4, full=1, overflow=1, evt_count=4. Pulse clr_ovf → overflow=0. Drain → entries in order, out_valid=0 after the fourth pop.
- Full FIFO, push and pop in the same cycle → level stays 4, overflow stays 0, head advances by one.
- Assert reset low asynchronously mid-drain between edges → all outputs 0 immediately. Release → the next rco event lands as the sole entry.
